// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchroniser plus per-bit counter debounce for raw board switches.
// Latency: a held raw change reaches switches DEBOUNCE_CYCLES+2 edges after it is first sampled.
// Backpressure: none; free-running, every bit is conditioned continuously and independently.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   n_reset   synchronous active-low reset
//   sw_raw    asynchronous raw switch levels from the pins
//   switches  debounced, registered switch levels
//   sw_rise   one-cycle pulse per bit on a debounced 0->1 (edge detect build only, else 0)
//   sw_fall   one-cycle pulse per bit on a debounced 1->0 (edge detect build only, else 0)
//   stable    high when every synchronised bit equals its debounced output
//
// Optional feature macro: SWITCH_EDGE_DETECT_EN builds the sw_rise/sw_fall edge flops.
module switch_debouncer #(
  parameter int WIDTH           = 9,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             stable
);

  // Count value on which a persistent mismatch is committed to the output.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] mismatch;
  logic [WIDTH-1:0] commit;
  logic [WIDTH-1:0] switches_nxt;

  // State register: synchroniser, counters and debounced levels.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      s1       <= '0;
      s2       <= '0;
      switches <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1       <= sw_raw;
      s2       <= s1;
      switches <= switches_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // Next-state logic. A bit that matches its output always clears its counter,
  // so a bounce back to the old level restarts the count from zero. The counter
  // is cleared on the commit edge itself, so it never needs to hold more than N-1.
  always_comb begin
    mismatch     = s2 ^ switches;
    commit       = '0;
    cnt_nxt      = '{default: '0};
    switches_nxt = switches;
    for (int i = 0; i < WIDTH; i++) begin
      commit[i] = mismatch[i] && (cnt[i] == CNT_LAST);
      if (mismatch[i] && !commit[i]) begin
        cnt_nxt[i] = cnt[i] + 1'b1;
      end
      if (commit[i]) begin
        switches_nxt[i] = s2[i];
      end
    end
  end

  // Output logic. stable is the only combinational output and depends on flops only.
  assign stable = (s2 == switches);

`ifdef SWITCH_EDGE_DETECT_EN
  // A commit always moves the output to s2, so s2 gives the direction of the edge.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      sw_rise <= commit & s2;
      sw_fall <= commit & ~s2;
    end
  end
`else
  assign sw_rise = '0;
  assign sw_fall = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed and random stimulus for switch_debouncer, scoreboard-checked.
// A window-based reference model pushes the expected outputs for every edge; a monitor pops them.
// Directed checks additionally pin the absolute latencies of the debounce.
module tb_switch_debouncer;

  localparam int W = 9;
  localparam int N = 4;

  logic         clk;
  logic         n_reset;
  logic [W-1:0] sw_raw;
  logic [W-1:0] switches;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         stable;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] sw;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         stable;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: two-stage delay line, debounced level and the last N
  // synchronised samples. A bit commits once all N samples in the window disagree
  // with its current output.
  logic [W-1:0] m_s1, m_s2, m_out;
  logic [W-1:0] win[$];

  switch_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .sw_raw   (sw_raw),
    .switches (switches),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .stable   (stable)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step();
    logic [W-1:0] commit_v;
    logic [W-1:0] rise_v;
    logic [W-1:0] fall_v;
    bit           all_diff;
    exp_t         e;
    commit_v = '0;
    rise_v   = '0;
    fall_v   = '0;
    if (!n_reset) begin
      m_s1  = '0;
      m_s2  = '0;
      m_out = '0;
      win.delete();
    end else begin
      win.push_back(m_s2);
      if (win.size() > N) void'(win.pop_front());
      if (win.size() == N) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          foreach (win[k]) if (win[k][b] == m_out[b]) all_diff = 1'b0;
          commit_v[b] = all_diff;
        end
      end
      rise_v = commit_v & ~m_out;
      fall_v = commit_v & m_out;
      m_out  = m_out ^ commit_v;
      m_s2   = m_s1;
      m_s1   = sw_raw;
    end
`ifndef SWITCH_EDGE_DETECT_EN
    rise_v = '0;
    fall_v = '0;
`endif
    e.sw     = m_out;
    e.rise   = rise_v;
    e.fall   = fall_v;
    e.stable = (m_s2 == m_out);
    exp_q.push_back(e);
  endtask

  // Model: computes the expected post-edge outputs on every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: every cycle the DUT presents a new output set, compared away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_switches", 32'(switches), 32'(e.sw));
        chk("sb_sw_rise",  32'(sw_rise),  32'(e.rise));
        chk("sb_sw_fall",  32'(sw_fall),  32'(e.fall));
        chk("sb_stable",   32'(stable),   32'(e.stable));
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Directed stimulus with absolute latency checks, then a random soak.
  initial begin
    n_reset = 1'b0;
    sw_raw  = 9'h1FF;

    // Reset with all switches high.
    wait_edges(3);
    chk("rst_switches", 32'(switches), 32'h0);
    chk("rst_rise",     32'(sw_rise),  32'h0);
    chk("rst_fall",     32'(sw_fall),  32'h0);
    chk("rst_stable",   32'(stable),   32'h1);
    n_reset = 1'b1;
    wait_edges(5);
    chk("rel_5_edges", 32'(switches), 32'h0);
    wait_edges(1);
    chk("rel_6_edges", 32'(switches), 32'h1FF);
    sw_raw = 9'h000;
    wait_edges(10);
    chk("all_low", 32'(switches), 32'h0);

    // Clean step on bit 0.
    sw_raw = 9'h001;
    wait_edges(5);
    chk("step_5_edges", 32'(switches[0]), 32'h0);
    chk("step_unstable", 32'(stable), 32'h0);
    wait_edges(1);
    chk("step_6_edges", 32'(switches[0]), 32'h1);
    chk("step_stable", 32'(stable), 32'h1);
`ifdef SWITCH_EDGE_DETECT_EN
    chk("step_rise", 32'(sw_rise), 32'h001);
`else
    chk("step_rise_off", 32'(sw_rise), 32'h0);
`endif
    wait_edges(1);
    chk("step_rise_gone", 32'(sw_rise), 32'h0);
    wait_edges(8);
    sw_raw = 9'h000;
    wait_edges(10);

    // Bounce on bit 3: runs of two are shorter than N and never commit.
    for (int i = 0; i < 10; i++) begin
      sw_raw[3] = ~sw_raw[3];
      wait_edges(2);
    end
    sw_raw = 9'h000;
    wait_edges(10);
    chk("bounce_switches", 32'(switches), 32'h0);
    chk("bounce_stable", 32'(stable), 32'h1);

    // Glitch of N-1 cycles on bit 8, then a real step.
    sw_raw = 9'h100;
    wait_edges(3);
    sw_raw = 9'h000;
    wait_edges(10);
    chk("glitch_switches", 32'(switches), 32'h0);
    sw_raw = 9'h100;
    wait_edges(6);
    chk("flag_set", 32'(switches), 32'h100);
    wait_edges(4);
    sw_raw = 9'h000;
    wait_edges(10);

    // Simultaneous change of several bits.
    sw_raw = 9'h1A5;
    wait_edges(5);
    chk("simul_5_edges", 32'(switches), 32'h0);
    wait_edges(1);
    chk("simul_up", 32'(switches), 32'h1A5);
    wait_edges(4);
    sw_raw = 9'h000;
    wait_edges(6);
    chk("simul_down", 32'(switches), 32'h0);
    wait_edges(4);

    // Reset mid-count discards progress.
    sw_raw = 9'h004;
    wait_edges(4);
    n_reset = 1'b0;
    wait_edges(1);
    chk("midrst_clear", 32'(switches), 32'h0);
    n_reset = 1'b1;
    wait_edges(5);
    chk("midrst_5_edges", 32'(switches[2]), 32'h0);
    wait_edges(1);
    chk("midrst_6_edges", 32'(switches[2]), 32'h1);

    // Random soak: sparse bit flips and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) sw_raw[$urandom_range(W-1)] ^= 1'b1;
      n_reset = ($urandom_range(79) != 0);
      wait_edges(1);
    end
    n_reset = 1'b1;
    wait_edges(12);
    chk("final_stable", 32'(stable), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
